// File: rtl/vec_issue_pkg.sv
// Shared entry layout, state encodings and a saturating-increment helper for the vector issue queue.
package vec_issue_pkg;

    localparam int unsigned ISSUE_XLEN = 32;

    typedef struct packed {
        logic [ISSUE_XLEN-1:0] instr;
        logic [ISSUE_XLEN-1:0] rs1;
        logic [ISSUE_XLEN-1:0] rs2;
    } issue_entry_t;

    typedef enum logic [1:0] {
        ISS_IDLE    = 2'd0,
        ISS_VALID   = 2'd1,
        ISS_BLOCKED = 2'd2
    } iss_state_e;

    typedef enum logic {
        RESP_EMPTY = 1'b0,
        RESP_FULL  = 1'b1
    } resp_state_e;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/vec_issue_fifo.sv
// DEPTH-entry FIFO of issue entries with push/pop/flush; exposes the registered and next count.
module vec_issue_fifo
    import vec_issue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  issue_entry_t                 wdata,
    output issue_entry_t                 rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [$clog2(DEPTH+1)-1:0]   count_next_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    issue_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // A flush always wins over a push; pops never underflow.
    assign do_push = push && !flush && (count_q != DEPTH_C);
    assign do_pop  = pop && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata        = mem_q[rd_ptr_q];
    assign count        = count_q;
    assign count_next_c = count_d;

endmodule

// File: rtl/vec_issue_queue.sv
// Buffered issue agent between the scalar core and the vector processor.
// Optional VEC_ISSUE_STATS_EN adds saturating issue/stall counters.
module vec_issue_queue
    import vec_issue_pkg::*;
#(
    parameter int unsigned XLEN            = ISSUE_XLEN,
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   sp_valid,
    output logic                                   sp_ready,
    input  logic [XLEN-1:0]                        sp_instruction,
    input  logic [XLEN-1:0]                        sp_rs1_data,
    input  logic [XLEN-1:0]                        sp_rs2_data,
    input  logic                                   flush,
    output logic                                   inst_valid,
    input  logic                                   vec_pro_ready,
    output logic [XLEN-1:0]                        instruction,
    output logic [XLEN-1:0]                        rs1_data,
    output logic [XLEN-1:0]                        rs2_data,
    input  logic                                   vec_pro_ack,
    input  logic [XLEN-1:0]                        csr_out,
    output logic                                   scalar_pro_ready,
    output logic                                   sp_resp_valid,
    output logic [XLEN-1:0]                        sp_resp_data,
    input  logic                                   sp_resp_ready,
    output logic [$clog2(DEPTH+1)-1:0]             q_count,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
`ifdef VEC_ISSUE_STATS_EN
    output logic [31:0]                            stat_issued,
    output logic [31:0]                            stat_stall,
`endif
    output logic                                   ack_err
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [OUT_W-1:0] MAX_C   = OUT_W'(MAX_OUTSTANDING);

    iss_state_e       iss_q, iss_d;
    resp_state_e      resp_q, resp_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic [XLEN-1:0]  resp_data_q, resp_data_d;
    logic             ack_err_q, ack_err_d;

    issue_entry_t     wr_entry, head_entry;
    logic [CNT_W-1:0] cnt_q, cnt_next;
    logic             push, transfer, ack_take;

    assign wr_entry = '{instr: ISSUE_XLEN'(sp_instruction),
                        rs1:   ISSUE_XLEN'(sp_rs1_data),
                        rs2:   ISSUE_XLEN'(sp_rs2_data)};

    vec_issue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .pop          (transfer),
        .flush        (flush),
        .wdata        (wr_entry),
        .rdata        (head_entry),
        .count        (cnt_q),
        .count_next_c (cnt_next)
    );

    // Handshake qualifiers; sp_ready looks only at the registered count.
    assign sp_ready         = (cnt_q != DEPTH_C) && !flush && !reset;
    assign push             = sp_valid && sp_ready;
    assign inst_valid       = (iss_q == ISS_VALID);
    assign transfer         = inst_valid && vec_pro_ready;
    assign scalar_pro_ready = (resp_q == RESP_EMPTY) || sp_resp_ready;
    assign ack_take         = vec_pro_ack && scalar_pro_ready && (out_q != '0);

    // Issue FSM, outstanding counter, response register and error flag next-state.
    always_comb begin
        iss_d       = iss_q;
        resp_d      = resp_q;
        out_d       = out_q;
        resp_data_d = resp_data_q;
        ack_err_d   = ack_err_q;

        if (transfer && !ack_take)      out_d = out_q + OUT_W'(1);
        else if (!transfer && ack_take) out_d = out_q - OUT_W'(1);

        if (vec_pro_ack && (out_q == '0)) ack_err_d = 1'b1;

        unique case (iss_q)
            ISS_IDLE: begin
                if (cnt_next != '0) iss_d = (out_d == MAX_C) ? ISS_BLOCKED : ISS_VALID;
            end
            ISS_VALID, ISS_BLOCKED: begin
                if (cnt_next == '0)      iss_d = ISS_IDLE;
                else if (out_d == MAX_C) iss_d = ISS_BLOCKED;
                else                     iss_d = ISS_VALID;
            end
            default: iss_d = ISS_IDLE;
        endcase

        // A taken ack refills even when the held response drains this cycle.
        if (ack_take) begin
            resp_d      = RESP_FULL;
            resp_data_d = csr_out;
        end else if ((resp_q == RESP_FULL) && sp_resp_ready) begin
            resp_d = RESP_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            iss_q       <= ISS_IDLE;
            resp_q      <= RESP_EMPTY;
            out_q       <= '0;
            resp_data_q <= '0;
            ack_err_q   <= 1'b0;
        end else begin
            iss_q       <= iss_d;
            resp_q      <= resp_d;
            out_q       <= out_d;
            resp_data_q <= resp_data_d;
            ack_err_q   <= ack_err_d;
        end
    end

    assign instruction   = XLEN'(head_entry.instr);
    assign rs1_data      = XLEN'(head_entry.rs1);
    assign rs2_data      = XLEN'(head_entry.rs2);
    assign sp_resp_valid = (resp_q == RESP_FULL);
    assign sp_resp_data  = resp_data_q;
    assign q_count       = cnt_q;
    assign outstanding   = out_q;
    assign ack_err       = ack_err_q;

`ifdef VEC_ISSUE_STATS_EN
    logic [31:0] stat_issued_q, stat_stall_q;
    logic        stall_c;

    assign stall_c = (iss_q == ISS_BLOCKED) || ((iss_q == ISS_VALID) && !vec_pro_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_issued_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            stat_issued_q <= sat_inc32(stat_issued_q, transfer);
            stat_stall_q  <= sat_inc32(stat_stall_q, stall_c);
        end
    end

    assign stat_issued = stat_issued_q;
    assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_vec_issue_queue.sv
// Self-checking bench for vec_issue_queue: directed scenarios plus random traffic against a queue-based model.
module tb_vec_issue_queue;

    localparam int unsigned DEPTH = 4;
    localparam int          MAXO  = 2;

    logic        clk, reset;
    logic        sp_valid, sp_ready;
    logic [31:0] sp_instruction, sp_rs1_data, sp_rs2_data;
    logic        flush, inst_valid, vec_pro_ready;
    logic [31:0] instruction, rs1_data, rs2_data;
    logic        vec_pro_ack;
    logic [31:0] csr_out;
    logic        scalar_pro_ready, sp_resp_valid;
    logic [31:0] sp_resp_data;
    logic        sp_resp_ready;
    logic [2:0]  q_count;
    logic [1:0]  outstanding;
    logic        ack_err;
`ifdef VEC_ISSUE_STATS_EN
    logic [31:0] stat_issued, stat_stall;
`endif

    vec_issue_queue #(
        .XLEN            (32),
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .sp_valid         (sp_valid),
        .sp_ready         (sp_ready),
        .sp_instruction   (sp_instruction),
        .sp_rs1_data      (sp_rs1_data),
        .sp_rs2_data      (sp_rs2_data),
        .flush            (flush),
        .inst_valid       (inst_valid),
        .vec_pro_ready    (vec_pro_ready),
        .instruction      (instruction),
        .rs1_data         (rs1_data),
        .rs2_data         (rs2_data),
        .vec_pro_ack      (vec_pro_ack),
        .csr_out          (csr_out),
        .scalar_pro_ready (scalar_pro_ready),
        .sp_resp_valid    (sp_resp_valid),
        .sp_resp_data     (sp_resp_data),
        .sp_resp_ready    (sp_resp_ready),
        .q_count          (q_count),
        .outstanding      (outstanding),
`ifdef VEC_ISSUE_STATS_EN
        .stat_issued      (stat_issued),
        .stat_stall       (stat_stall),
`endif
        .ack_err          (ack_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] i;
        logic [31:0] a;
        logic [31:0] b;
    } ent_t;

    ent_t        mq[$];
    int          m_out;
    bit          m_rv;
    logic [31:0] m_rd;
    bit          m_err;
    logic [31:0] m_iss, m_stall;
    int          checks, errors;
    bit          chk_en;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output with the model a little after the input change.
    task automatic settle();
        bit exp_iv;
        #2;
        if (!chk_en) return;
        exp_iv = (mq.size() > 0) && (m_out < MAXO);
        check("sp_ready", 32'(sp_ready), 32'((mq.size() < DEPTH) && !flush && !reset));
        check("inst_valid", 32'(inst_valid), 32'(exp_iv));
        if (exp_iv) begin
            check("instruction", instruction, mq[0].i);
            check("rs1_data", rs1_data, mq[0].a);
            check("rs2_data", rs2_data, mq[0].b);
        end
        check("scalar_pro_ready", 32'(scalar_pro_ready), 32'(!m_rv || sp_resp_ready));
        check("sp_resp_valid", 32'(sp_resp_valid), 32'(m_rv));
        check("sp_resp_data", sp_resp_data, m_rd);
        check("q_count", 32'(q_count), 32'(mq.size()));
        check("outstanding", 32'(outstanding), 32'(m_out));
        check("ack_err", 32'(ack_err), 32'(m_err));
`ifdef VEC_ISSUE_STATS_EN
        check("stat_issued", stat_issued, m_iss);
        check("stat_stall", stat_stall, m_stall);
`endif
    endtask

    // Advance the model by one cycle from the current inputs, then clock the DUT.
    task automatic tick();
        bit   iv, spr, srdy, xfer, push, take, stall;
        ent_t e;
        iv   = (mq.size() > 0) && (m_out < MAXO);
        spr  = (mq.size() < DEPTH) && !flush && !reset;
        srdy = !m_rv || sp_resp_ready;
        xfer = iv && vec_pro_ready;
        push = sp_valid && spr;
        take = vec_pro_ack && srdy && (m_out > 0);
        if (reset) begin
            mq.delete();
            m_out = 0; m_rv = 0; m_rd = '0; m_err = 0; m_iss = '0; m_stall = '0;
        end else begin
            stall = iv ? !vec_pro_ready : (mq.size() > 0);
            if (stall && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (xfer && m_iss != 32'hFFFF_FFFF) m_iss++;
            if (vec_pro_ack && m_out == 0) m_err = 1;
            if (xfer) void'(mq.pop_front());
            if (flush) mq.delete();
            if (push) begin
                e.i = sp_instruction; e.a = sp_rs1_data; e.b = sp_rs2_data;
                mq.push_back(e);
            end
            if (xfer) m_out++;
            if (take) m_out--;
            if (take) begin
                m_rv = 1; m_rd = csr_out;
            end else if (sp_resp_ready) begin
                m_rv = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        sp_valid = 0; flush = 0; vec_pro_ready = 0; vec_pro_ack = 0; sp_resp_ready = 1;
        sp_instruction = $urandom(); sp_rs1_data = $urandom(); sp_rs2_data = $urandom();
        csr_out = $urandom();
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        settle(); tick();
        settle(); tick();
        reset = 0;
    endtask

    task automatic rand_operands();
        sp_rs1_data = $urandom(); sp_rs2_data = $urandom();
    endtask

    // Issue everything and ack everything, bounded.
    task automatic drain();
        bit done;
        done = 0;
        sp_valid = 0; flush = 0; vec_pro_ready = 1; sp_resp_ready = 1;
        for (int k = 0; k < 40 && !done; k++) begin
            vec_pro_ack = (m_out > 0);
            csr_out = $urandom();
            settle(); tick();
            done = (mq.size() == 0) && (m_out == 0);
        end
        vec_pro_ack = 0; vec_pro_ready = 0;
        check("drain_done", 32'(done), 32'd1);
    endtask

    task automatic scen_full();
        vec_pro_ready = 0; vec_pro_ack = 0;
        for (int k = 0; k < 4; k++) begin
            sp_valid = 1; sp_instruction = $urandom(); rand_operands();
            settle(); tick();
        end
        sp_instruction = 32'hF1F1_0005; rand_operands();
        settle();
        check("s2_count_full", 32'(q_count), 32'd4);
        check("s2_ready_full", 32'(sp_ready), 32'd0);
        tick();
        vec_pro_ready = 1;
        settle();
        check("s2_ready_pop", 32'(sp_ready), 32'd0);
        tick();
        vec_pro_ready = 0;
        settle();
        check("s2_accept", 32'(sp_ready), 32'd1);
        tick();
        sp_valid = 0;
        settle();
        check("s2_count_refill", 32'(q_count), 32'd4);
        tick();
        drain();
    endtask

    initial begin
        logic [31:0] r0, r1, r2, x1, x2;
        checks = 0; errors = 0; chk_en = 0;
        m_out = 0; m_rv = 0; m_rd = '0; m_err = 0; m_iss = '0; m_stall = '0;
        do_reset();
        chk_en = 1;
        settle();
        check("rst_scalar_pro_ready", 32'(scalar_pro_ready), 32'd1);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        tick();

        // In-order issue with one-cycle latency; ack two cycles after each push.
        r0 = $urandom(); r1 = $urandom(); r2 = $urandom();
        vec_pro_ready = 1; sp_resp_ready = 1;
        sp_valid = 1; sp_instruction = 32'h0C00_7057; rand_operands();
        settle(); tick();
        sp_instruction = 32'h0200_0007; rand_operands();
        settle();
        check("s1_latency", 32'(inst_valid), 32'd1);
        check("s1_head0", instruction, 32'h0C00_7057);
        tick();
        sp_instruction = 32'h0201_0207; rand_operands(); vec_pro_ack = 1; csr_out = r0;
        settle();
        check("s1_head1", instruction, 32'h0200_0007);
        tick();
        sp_valid = 0; csr_out = r1;
        settle();
        check("s1_head2", instruction, 32'h0201_0207);
        check("s1_resp0", sp_resp_data, r0);
        check("s1_out", 32'(outstanding), 32'd1);
        tick();
        csr_out = r2;
        settle();
        check("s1_resp1", sp_resp_data, r1);
        tick();
        vec_pro_ack = 0;
        settle();
        check("s1_resp2", sp_resp_data, r2);
        check("s1_out_end", 32'(outstanding), 32'd0);
        tick();

        scen_full();

        // Outstanding limit blocks the third issue until one ack.
        vec_pro_ready = 0;
        for (int k = 0; k < 3; k++) begin
            sp_valid = 1; sp_instruction = $urandom(); rand_operands();
            settle(); tick();
        end
        sp_valid = 0; vec_pro_ready = 1;
        settle(); tick();
        settle(); tick();
        settle();
        check("s3_blocked", 32'(inst_valid), 32'd0);
        check("s3_out_max", 32'(outstanding), 32'd2);
        check("s3_count", 32'(q_count), 32'd1);
        tick();
        vec_pro_ack = 1; csr_out = $urandom();
        settle(); tick();
        vec_pro_ack = 0;
        settle();
        check("s3_reissue", 32'(inst_valid), 32'd1);
        tick();
        vec_pro_ready = 0;
        settle();
        check("s3_out_after", 32'(outstanding), 32'd2);
        tick();

        // Response back-pressure, then same-cycle drain and refill.
        x1 = $urandom(); x2 = $urandom();
        sp_resp_ready = 0; vec_pro_ack = 1; csr_out = x1;
        settle(); tick();
        csr_out = x2;
        settle();
        check("s4_spr_low", 32'(scalar_pro_ready), 32'd0);
        check("s4_held", sp_resp_data, x1);
        tick();
        sp_resp_ready = 1;
        settle();
        check("s4_spr_high", 32'(scalar_pro_ready), 32'd1);
        tick();
        vec_pro_ack = 0;
        settle();
        check("s4_second", sp_resp_data, x2);
        check("s4_valid", 32'(sp_resp_valid), 32'd1);
        check("s4_out", 32'(outstanding), 32'd0);
        tick();

        // Flush with a same-cycle push, then a spurious ack.
        vec_pro_ready = 0;
        for (int k = 0; k < 3; k++) begin
            sp_valid = 1; sp_instruction = $urandom(); rand_operands();
            settle(); tick();
        end
        flush = 1;
        settle();
        check("s5_push_refused", 32'(sp_ready), 32'd0);
        tick();
        flush = 0; sp_valid = 0;
        settle();
        check("s5_count", 32'(q_count), 32'd0);
        check("s5_out", 32'(outstanding), 32'd0);
        tick();
        vec_pro_ack = 1;
        settle(); tick();
        vec_pro_ack = 0;
        settle();
        check("s5_ack_err", 32'(ack_err), 32'd1);
        check("s5_no_resp", 32'(sp_resp_valid), 32'd0);
        tick();

        // Counters from a fresh reset, then reset in the middle of traffic.
        do_reset();
        scen_full();
`ifdef VEC_ISSUE_STATS_EN
        check("s6_issued", stat_issued, 32'd5);
`endif
        vec_pro_ready = 1; sp_resp_ready = 0;
        for (int k = 0; k < 4; k++) begin
            sp_valid = 1; sp_instruction = $urandom(); rand_operands();
            vec_pro_ack = (k == 2); csr_out = $urandom();
            settle(); tick();
        end
        do_reset();
        settle();
        check("s6_rst_count", 32'(q_count), 32'd0);
        check("s6_rst_out", 32'(outstanding), 32'd0);
        check("s6_rst_resp", 32'(sp_resp_valid), 32'd0);
`ifdef VEC_ISSUE_STATS_EN
        check("s6_rst_issued", stat_issued, 32'd0);
        check("s6_rst_stall", stat_stall, 32'd0);
`endif
        tick();

        // Random traffic against the model.
        for (int n = 0; n < 800; n++) begin
            sp_valid       = ($urandom_range(0, 9) < 6);
            sp_instruction = $urandom(); rand_operands();
            vec_pro_ready  = ($urandom_range(0, 9) < 6);
            vec_pro_ack    = ($urandom_range(0, 9) < 4);
            csr_out        = $urandom();
            sp_resp_ready  = ($urandom_range(0, 9) < 6);
            flush          = ($urandom_range(0, 24) == 0);
            reset          = ($urandom_range(0, 199) == 0);
            settle(); tick();
        end
        reset = 0; flush = 0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
